sync_counter: RTL and testbench

- Free-running synchronous binary up-counter with wrap-around. Default width is 4 bits.
- Advances by one on every rising clock edge while reset is deasserted.
- Adds status outputs: terminal-count flag, Gray-coded copy of the count, and a wrap-event counter.
- Used as a timebase/sequence generator. Only clk, reset and count are mandatory connections; all other outputs may be left unconnected.

---
 rtl/sync_counter.sv | 41 ++++
 tb/tb_sync_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_counter.sv
// Free-running binary up-counter with terminal-count, Gray copy
// and a wrap-event counter.
module sync_counter #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  count_gray,
  output logic              tc,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [WIDTH-1:0]  MAX  = '1;
  localparam logic [WIDTH-1:0]  ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WONE = WRAP_W'(1);

  logic [WIDTH-1:0] nxt;

  assign nxt = count + ONE;
  assign tc  = (count == MAX);

  // Gray copy is derived from the next value so it stays in phase
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      count_gray <= '0;
      wrap       <= 1'b0;
      wrap_count <= '0;
    end else begin
      count      <= nxt;
      count_gray <= nxt ^ (nxt >> 1);
      wrap       <= tc;
      if (tc)
        wrap_count <= wrap_count + WONE;
    end
  end

endmodule

// File: tb/tb_sync_counter.sv
// Scoreboard bench for sync_counter: default (4/8) and narrow (3/2)
// instances checked against an arithmetic reference model.
module tb_sync_counter;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  logic [3:0] a_cnt, a_gray;
  logic       a_tc, a_wrap;
  logic [7:0] a_wc;

  logic [2:0] b_cnt, b_gray;
  logic       b_tc, b_wrap;
  logic [1:0] b_wc;

  always #5 clk = ~clk;

  sync_counter u_a (
    .clk        (clk),
    .reset      (rst_a),
    .count      (a_cnt),
    .count_gray (a_gray),
    .tc         (a_tc),
    .wrap       (a_wrap),
    .wrap_count (a_wc)
  );

  sync_counter #(.WIDTH(3), .WRAP_W(2)) u_b (
    .clk        (clk),
    .reset      (rst_b),
    .count      (b_cnt),
    .count_gray (b_gray),
    .tc         (b_tc),
    .wrap       (b_wrap),
    .wrap_count (b_wc)
  );

  typedef struct {
    int cnt;
    int gray;
    int tc;
    int wrap;
    int wc;
    bit step;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t q[$];
  int tests = 0;
  int fails = 0;

  int ma_cnt = 0, ma_wc = 0, mb_cnt = 0, mb_wc = 0;
  bit ma_init = 0, mb_init = 0;

  function automatic exp_t model(inout int cnt, inout int wc,
                                 inout bit init, input bit r,
                                 input int w, input int ww);
    exp_t e;
    int   m;
    m = 1 << w;
    if (r) begin
      e.step = 0;
      e.wrap = 0;
      cnt    = 0;
      wc     = 0;
    end else begin
      e.step = init;
      e.wrap = (cnt == m - 1) ? 1 : 0;
      cnt    = (cnt + 1) % m;
      if (e.wrap == 1)
        wc = (wc + 1) % (1 << ww);
    end
    init   = 1;
    e.cnt  = cnt;
    e.gray = cnt ^ (cnt >> 1);
    e.tc   = (cnt == m - 1) ? 1 : 0;
    e.wc   = wc;
    return e;
  endfunction

  task automatic edge_push();
    pair_t p;
    p.a = model(ma_cnt, ma_wc, ma_init, rst_a, 4, 8);
    p.b = model(mb_cnt, mb_wc, mb_init, rst_b, 3, 2);
    q.push_back(p);
  endtask

  // Called just after a rising edge; sets reset for the next edge
  task automatic drive(input bit ra, input bit pulse);
    if (pulse) begin
      #2 rst_a = 1'b1;
      #2 rst_a = 1'b0;
      #3;
    end else begin
      #7;
    end
    rst_a = ra;
    rst_b = 1'b0;
    @(posedge clk);
    edge_push();
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  pair_t      cur;
  logic [3:0] pa_gray;
  logic [2:0] pb_gray;

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        cur = q.pop_front();
        chk("a_count", 32'(a_cnt), cur.a.cnt);
        chk("a_gray", 32'(a_gray), cur.a.gray);
        chk("a_tc", 32'(a_tc), cur.a.tc);
        chk("a_wrap", 32'(a_wrap), cur.a.wrap);
        chk("a_wrap_count", 32'(a_wc), cur.a.wc);
        if (cur.a.step)
          chk("a_gray_step", $countones(a_gray ^ pa_gray), 1);
        chk("b_count", 32'(b_cnt), cur.b.cnt);
        chk("b_gray", 32'(b_gray), cur.b.gray);
        chk("b_tc", 32'(b_tc), cur.b.tc);
        chk("b_wrap", 32'(b_wrap), cur.b.wrap);
        chk("b_wrap_count", 32'(b_wc), cur.b.wc);
        if (cur.b.step)
          chk("b_gray_step", $countones(b_gray ^ pb_gray), 1);
        pa_gray = a_gray;
        pb_gray = b_gray;
      end
    end
  end

  initial begin
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    edge_push();
    // release at 12 ns, then free-run past the first wrap
    for (int i = 0; i < 30; i++)
      drive(1'b0, 1'b0);
    n = 0;
    while (ma_cnt != 9 && n < 20) begin
      drive(1'b0, 1'b0);
      n++;
    end
    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1);
    n = 0;
    while (ma_cnt != 15 && n < 20) begin
      drive(1'b0, 1'b0);
      n++;
    end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
